// File: rtl/regfile_param.sv
`default_nettype none
// ============================================================================
// Module      : regfile_param
// Description : Parametrised register file, DEPTH words of WIDTH bits.
//               One byte-enabled write port and two independent combinational
//               read ports, for the decode stage. Register 0 can be hardwired
//               to zero (ZERO_REG).
//               Optional feature macro: REGFILE_BYPASS_EN
//                 defined   -> same-cycle write-through forwarding to reads
//                 undefined -> reads always return stored contents
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_param #(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 32,
  parameter bit ZERO_REG = 1'b1,
  localparam int AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               we,
  input  logic [AW-1:0]      waddr,
  input  logic [WIDTH-1:0]   wdata,
  input  logic [WIDTH/8-1:0] wbe,
  input  logic [AW-1:0]      raddr_a,
  input  logic [AW-1:0]      raddr_b,
  output logic [WIDTH-1:0]   rdata_a,
  output logic [WIDTH-1:0]   rdata_b
);

  // Number of byte lanes per register.
  localparam int NB = WIDTH / 8;

  // DEPTH expressed at AW+1 bits so an address can be range-checked without
  // widening it to 32 bits (DEPTH may equal 2**AW).
  localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);

  // --------------------------------------------------------------------------
  // Elaboration-time parameter sanity
  // --------------------------------------------------------------------------
  if ((WIDTH % 8) != 0 || WIDTH < 8) begin : g_bad_width
    $error("regfile_param: WIDTH must be a non-zero multiple of 8");
  end
  if (DEPTH < 1) begin : g_bad_depth
    $error("regfile_param: DEPTH must be at least 1");
  end

  // --------------------------------------------------------------------------
  // Helpers
  // --------------------------------------------------------------------------
  // True when addr selects a physically present register; non-power-of-two
  // depths leave a hole at the top of the address space that must not wrap.
  function automatic logic addr_in_range(input logic [AW-1:0] addr);
    return ({1'b0, addr} < DEPTH_C);
  endfunction

  // True when addr is the hardwired zero register.
  function automatic logic addr_is_zero_reg(input logic [AW-1:0] addr);
    return ZERO_REG && (addr == '0);
  endfunction

  // Byte-wise merge: lanes with be[k]=1 take new_w, the rest keep old_w.
  function automatic logic [WIDTH-1:0] merge_bytes(
    input logic [WIDTH-1:0] old_w,
    input logic [WIDTH-1:0] new_w,
    input logic [NB-1:0]    be
  );
    logic [WIDTH-1:0] res;
    res = old_w;
    for (int k = 0; k < NB; k++) begin
      if (be[k]) begin
        res[8*k +: 8] = new_w[8*k +: 8];
      end
    end
    return res;
  endfunction

  // --------------------------------------------------------------------------
  // Write qualification
  // --------------------------------------------------------------------------
  // A write is effective only when enabled, out of reset, targeting a real
  // register, and not the hardwired zero register. The same qualifier gates
  // forwarding, so ignored writes are never visible on the read ports.
  logic write_ok;

  // Combine enable, reset and address legality into one write qualifier.
  always_comb begin
    write_ok = we && !reset && addr_in_range(waddr) && !addr_is_zero_reg(waddr);
  end

  // --------------------------------------------------------------------------
  // Storage: one enable flop group per byte lane of every register
  // --------------------------------------------------------------------------
  wire [DEPTH-1:0][WIDTH-1:0] word_q;
  wire [DEPTH-1:0][NB-1:0]    lane_en;

  for (genvar r = 0; r < DEPTH; r++) begin : g_reg
    localparam logic [AW-1:0] IDX = AW'(r);

    if (ZERO_REG && (r == 0)) begin : g_zero
      // No storage: register 0 is a constant.
      assign word_q[r]  = '0;
      assign lane_en[r] = '0;
    end else begin : g_store
      // Lane enable = we & decode(waddr) & wbe[k] (we/reset/range in write_ok).
      assign lane_en[r] = (write_ok && (waddr == IDX)) ? wbe : '0;

      for (genvar k = 0; k < NB; k++) begin : g_lane
        logic [7:0] lane_q;

        // Byte lane flop: reset wins, otherwise load wdata byte when enabled.
        always_ff @(posedge clk) begin
          if (reset) begin
            lane_q <= '0;
          end else if (lane_en[r][k]) begin
            lane_q <= wdata[8*k +: 8];
          end
        end

        assign word_q[r][8*k +: 8] = lane_q;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Read ports
  // --------------------------------------------------------------------------
  logic [WIDTH-1:0] stored_a;
  logic [WIDTH-1:0] stored_b;

  // Port A stored-value mux; out-of-range and zero-register reads return 0.
  always_comb begin
    stored_a = '0;
    if (addr_in_range(raddr_a) && !addr_is_zero_reg(raddr_a)) begin
      stored_a = word_q[raddr_a];
    end
  end

  // Port B stored-value mux; independent copy of the port A logic.
  always_comb begin
    stored_b = '0;
    if (addr_in_range(raddr_b) && !addr_is_zero_reg(raddr_b)) begin
      stored_b = word_q[raddr_b];
    end
  end

`ifdef REGFILE_BYPASS_EN
  // Forwarding: an effective write to the register being read is visible in
  // the same cycle. write_ok already excludes reset and ignored writes, and
  // waddr==raddr implies stored_x is that register's current contents.
  logic fwd_a;
  logic fwd_b;

  // Port A output with write-through merge of enabled bytes.
  always_comb begin
    fwd_a   = write_ok && (waddr == raddr_a);
    rdata_a = fwd_a ? merge_bytes(stored_a, wdata, wbe) : stored_a;
  end

  // Port B output with write-through merge of enabled bytes.
  always_comb begin
    fwd_b   = write_ok && (waddr == raddr_b);
    rdata_b = fwd_b ? merge_bytes(stored_b, wdata, wbe) : stored_b;
  end
`else
  // No forwarding: a same-cycle read of the written register sees old data.
  always_comb begin
    rdata_a = stored_a;
    rdata_b = stored_b;
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_regfile_param.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_param
// Description : Scoreboard bench for regfile_param. Two instances share the
//               stimulus: DEPTH=32 (default) and DEPTH=20 (range holes).
//               Expectations follow REGFILE_BYPASS_EN when it is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_param;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic [3:0]  wbe;
  logic [4:0]  raddr_a;
  logic [4:0]  raddr_b;
  logic [31:0] rda32, rdb32, rda20, rdb20;

  regfile_param #(.WIDTH(32), .DEPTH(32), .ZERO_REG(1'b1)) u_dut32 (
    .clk(clk), .reset(reset), .we(we), .waddr(waddr), .wdata(wdata), .wbe(wbe),
    .raddr_a(raddr_a), .raddr_b(raddr_b), .rdata_a(rda32), .rdata_b(rdb32)
  );

  regfile_param #(.WIDTH(32), .DEPTH(20), .ZERO_REG(1'b1)) u_dut20 (
    .clk(clk), .reset(reset), .we(we), .waddr(waddr), .wdata(wdata), .wbe(wbe),
    .raddr_a(raddr_a), .raddr_b(raddr_b), .rdata_a(rda20), .rdata_b(rdb20)
  );

  always #5 clk = ~clk;

  // Sources: 0=A of DEPTH32, 1=B of DEPTH32, 2=A of DEPTH20, 3=B of DEPTH20
  typedef struct {
    int          cyc;
    int          src;
    int          id;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   cyc = 0;
  int   checks = 0;
  int   fails = 0;
  logic [31:0] act;
  string       sname;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: at the falling edge, pop every expectation issued for this cycle.
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc == cyc) begin
      e = sb.pop_front();
      case (e.src)
        0:       begin act = rda32; sname = "d32_a"; end
        1:       begin act = rdb32; sname = "d32_b"; end
        2:       begin act = rda20; sname = "d20_a"; end
        default: begin act = rdb20; sname = "d20_b"; end
      endcase
      checks++;
      if (act !== e.val) begin
        fails++;
        $display("FAIL chk%0d %s actual=%h expected=%h", e.id, sname, act, e.val);
      end
    end
  end

  // Apply one cycle of stimulus just after the rising edge.
  task automatic drive(input logic r, input logic w, input logic [4:0] wa,
                       input logic [31:0] wd, input logic [3:0] be,
                       input logic [4:0] ra, input logic [4:0] rb);
    @(posedge clk);
    #1;
    reset = r; we = w; waddr = wa; wdata = wd; wbe = be;
    raddr_a = ra; raddr_b = rb;
  endtask

  // Queue an expected read value for the cycle currently being driven.
  task automatic exp_rd(input int src, input logic [31:0] v, input int id);
    exp_t x;
    x.cyc = cyc; x.src = src; x.id = id; x.val = v;
    sb.push_back(x);
  endtask

  initial begin
    reset = 1'b1; we = 1'b0; waddr = '0; wdata = '0; wbe = '0;
    raddr_a = '0; raddr_b = '0;

    // Reset state, after the first (reset) edge
    drive(0, 0, 5'd0, 32'h0, 4'h0, 5'd5, 5'd0);
    for (int s = 0; s < 4; s++) exp_rd(s, 32'h0, 1);

    // 1. Writes to reg5 and reg0, then reset
    drive(0, 1, 5'd5, 32'hDEADBEEF, 4'hF, 5'd0, 5'd0);
    exp_rd(0, 32'h0, 2); exp_rd(1, 32'h0, 2);
    drive(0, 1, 5'd0, 32'hDEADBEEF, 4'hF, 5'd5, 5'd0);
    exp_rd(0, 32'hDEADBEEF, 3); exp_rd(1, 32'h0, 3);
    exp_rd(2, 32'hDEADBEEF, 3); exp_rd(3, 32'h0, 3);
    drive(0, 0, 5'd0, 32'h0, 4'h0, 5'd0, 5'd5);
    exp_rd(0, 32'h0, 4); exp_rd(1, 32'hDEADBEEF, 4);
    drive(1, 0, 5'd0, 32'h0, 4'h0, 5'd5, 5'd5);
    exp_rd(0, 32'hDEADBEEF, 5);
    for (int i = 0; i < 32; i++) begin
      drive(0, 0, 5'd0, 32'h0, 4'h0, 5'(i), 5'(31 - i));
      for (int s = 0; s < 4; s++) exp_rd(s, 32'h0, 6);
    end

    // 2. Byte enables on reg7
    drive(0, 1, 5'd7, 32'h11223344, 4'hF, 5'd7, 5'd0);
    exp_rd(0, BYP ? 32'h11223344 : 32'h0, 7);
    drive(0, 1, 5'd7, 32'hAABBCCDD, 4'b0101, 5'd7, 5'd7);
    exp_rd(0, BYP ? 32'h11BB33DD : 32'h11223344, 8);
    exp_rd(1, BYP ? 32'h11BB33DD : 32'h11223344, 8);
    drive(0, 1, 5'd7, 32'hFFFFFFFF, 4'h0, 5'd7, 5'd0);
    exp_rd(0, 32'h11BB33DD, 9);
    drive(0, 0, 5'd0, 32'h0, 4'h0, 5'd7, 5'd7);
    exp_rd(0, 32'h11BB33DD, 10); exp_rd(1, 32'h11BB33DD, 10);
    exp_rd(2, 32'h11BB33DD, 10);

    // 3. Dual read of reg3 / reg9
    drive(0, 1, 5'd3, 32'h00000003, 4'hF, 5'd0, 5'd0);
    drive(0, 1, 5'd9, 32'h00000009, 4'hF, 5'd3, 5'd0);
    exp_rd(0, 32'h3, 11);
    drive(0, 0, 5'd0, 32'h0, 4'h0, 5'd3, 5'd9);
    exp_rd(0, 32'h3, 12); exp_rd(1, 32'h9, 12);
    drive(0, 0, 5'd0, 32'h0, 4'h0, 5'd9, 5'd9);
    exp_rd(0, 32'h9, 13); exp_rd(1, 32'h9, 13);

    // 4. Same-cycle read/write of reg4
    drive(0, 1, 5'd4, 32'h1, 4'hF, 5'd0, 5'd0);
    drive(0, 1, 5'd4, 32'h2, 4'hF, 5'd4, 5'd0);
    exp_rd(0, BYP ? 32'h2 : 32'h1, 14);
    drive(0, 0, 5'd0, 32'h0, 4'h0, 5'd4, 5'd0);
    exp_rd(0, 32'h2, 15);

    // 5. Out-of-range write to 25 (only a real register in the DEPTH32 copy)
    drive(0, 1, 5'd25, 32'hFFFFFFFF, 4'hF, 5'd25, 5'd5);
    exp_rd(0, BYP ? 32'hFFFFFFFF : 32'h0, 16); exp_rd(1, 32'h0, 16);
    exp_rd(2, 32'h0, 16); exp_rd(3, 32'h0, 16);
    drive(0, 0, 5'd0, 32'h0, 4'h0, 5'd25, 5'd5);
    exp_rd(0, 32'hFFFFFFFF, 17); exp_rd(1, 32'h0, 17);
    exp_rd(2, 32'h0, 17); exp_rd(3, 32'h0, 17);
    drive(0, 0, 5'd0, 32'h0, 4'h0, 5'd9, 5'd25);
    exp_rd(2, 32'h9, 18); exp_rd(3, 32'h0, 18);

    // 6. Reset concurrent with a write to reg2
    drive(0, 1, 5'd2, 32'h12345678, 4'hF, 5'd0, 5'd0);
    drive(1, 1, 5'd2, 32'h5A5A5A5A, 4'hF, 5'd2, 5'd7);
    exp_rd(0, 32'h12345678, 19); exp_rd(1, 32'h11BB33DD, 19);
    drive(0, 0, 5'd0, 32'h0, 4'h0, 5'd2, 5'd7);
    exp_rd(0, 32'h0, 20); exp_rd(1, 32'h0, 20); exp_rd(2, 32'h0, 20);

    // Drain the scoreboard with a bounded wait
    for (int t = 0; t < 5 && sb.size() > 0; t++) @(posedge clk);
    if (sb.size() > 0) begin
      checks++;
      fails++;
      $display("FAIL drain pending=%0d expected=0", sb.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
`default_nettype wire
